// File: rtl/alu_result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_result_serializer                                        |
// | Description : Captures registered ALU results (data + carry) and emits     |
// |               each one as a frame of OUT_WIDTH-bit beats, MS beat first,   |
// |               on a valid/ready stream. One result in flight plus one       |
// |               pending slot; a third result while both are held is dropped  |
// |               and raises the sticky overrun flag.                          |
// |               Optional macro ALU_SER_CARRY_BYTE_EN appends a status beat   |
// |               {zeros, carry} to every frame.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_result_serializer #(
  parameter int DATA_WIDTH = 16,  // must be an integer multiple of OUT_WIDTH
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_carry,
  input  logic                  res_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NUM_BEATS = DATA_WIDTH / OUT_WIDTH;
`ifdef ALU_SER_CARRY_BYTE_EN
  localparam int TOTAL_BEATS = NUM_BEATS + 1;
`else
  localparam int TOTAL_BEATS = NUM_BEATS;
`endif
  // The status beat is always held below the data so the carry is captured
  // either way; without the macro the frame simply ends before reaching it.
  localparam int SHIFT_W = DATA_WIDTH + OUT_WIDTH;
  localparam int CNT_W   = $clog2(TOTAL_BEATS + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [SHIFT_W-1:0]  shift_reg;
  logic [CNT_W-1:0]    beat_cnt;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                pend_carry;
  logic                pend_full;
  logic                overrun_q;

  logic accept, last_accept;
  logic load_new, load_pend, capture_pend, release_pend, shift_en, set_overrun;

  function automatic logic [SHIFT_W-1:0] make_frame(input logic [DATA_WIDTH-1:0] d,
                                                    input logic c);
    return {d, {(OUT_WIDTH-1){1'b0}}, c};
  endfunction

  assign out_valid   = (state == SEND);
  assign accept      = out_valid && out_ready;
  assign last_accept = accept && (beat_cnt == CNT_W'(1));
  // Gate the beat so nothing leaks to the output (e.g. carry) while idle.
  assign out_data    = out_valid ? shift_reg[SHIFT_W-1 -: OUT_WIDTH] : '0;
  assign busy        = (state == SEND) || pend_full;
  assign overrun     = overrun_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (sync_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt    = state;
    load_new     = 1'b0;
    load_pend    = 1'b0;
    capture_pend = 1'b0;
    release_pend = 1'b0;
    shift_en     = 1'b0;
    set_overrun  = 1'b0;
    case (state)
      IDLE: begin
        if (res_valid) begin
          load_new  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (last_accept) begin
          // Frame completes: chain the next result with no bubble if any.
          if (pend_full) begin
            load_pend = 1'b1;
            if (res_valid) capture_pend = 1'b1;
            else           release_pend = 1'b1;
          end else if (res_valid) begin
            load_new = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          shift_en = accept;
          if (res_valid) begin
            if (pend_full) set_overrun  = 1'b1;  // keep the older result
            else           capture_pend = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and beat counter.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      shift_reg <= '0;
      beat_cnt  <= '0;
    end else if (load_new) begin
      shift_reg <= make_frame(res_data, res_carry);
      beat_cnt  <= CNT_W'(TOTAL_BEATS);
    end else if (load_pend) begin
      shift_reg <= make_frame(pend_data, pend_carry);
      beat_cnt  <= CNT_W'(TOTAL_BEATS);
    end else if (shift_en) begin
      shift_reg <= {shift_reg[SHIFT_W-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
      beat_cnt  <= beat_cnt - CNT_W'(1);
    end
  end

  // Pending slot and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pend_data  <= '0;
      pend_carry <= 1'b0;
      pend_full  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (capture_pend) begin
        pend_data  <= res_data;
        pend_carry <= res_carry;
        pend_full  <= 1'b1;
      end else if (release_pend) begin
        pend_full  <= 1'b0;
      end
      if (set_overrun) overrun_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_result_serializer                                     |
// | Description : Self-checking bench for alu_result_serializer: directed      |
// |               scenarios followed by random traffic, all checked against a  |
// |               queue-based reference model of the output stream.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_result_serializer;

  localparam int DW = 16;
  localparam int OW = 8;
  localparam int NB = DW / OW;

  logic          clk = 1'b0;
  logic          sync_rst;
  logic [DW-1:0] res_data;
  logic          res_carry;
  logic          res_valid;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overrun;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining beats of the frame being sent, plus pending result.
  logic [OW-1:0] cur_q[$];
  logic          m_pend_v;
  logic [DW-1:0] m_pend_d;
  logic          m_pend_c;
  logic          m_ovr;

  alu_result_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_valid (res_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Build the beat list of one result as the consumer should see it.
  function automatic void load_cur(input logic [DW-1:0] d, input logic c);
    cur_q = {};
    for (int i = NB - 1; i >= 0; i--) cur_q.push_back(d[i*OW +: OW]);
`ifdef ALU_SER_CARRY_BYTE_EN
    cur_q.push_back({{(OW-1){1'b0}}, c});
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur_q    = {};
    m_pend_v = 1'b0;
    m_pend_d = '0;
    m_pend_c = 1'b0;
    m_ovr    = 1'b0;
  endtask

  // One clock: compare present outputs to model, apply inputs, advance model.
  task automatic step(input logic rst, input logic rv, input logic [DW-1:0] d,
                      input logic c, input logic rdy);
    logic sending;
    @(negedge clk);
    sending = (cur_q.size() != 0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, sending});
    if (sending) chk("out_data", {24'd0, out_data}, {24'd0, cur_q[0]});
    chk("busy", {31'd0, busy}, {31'd0, sending || m_pend_v});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    sync_rst  = rst;
    res_valid = rv;
    res_data  = d;
    res_carry = c;
    out_ready = rdy;
    if (rst) begin
      model_reset();
    end else if (!sending) begin
      if (rv) load_cur(d, c);
    end else if (rdy && cur_q.size() == 1) begin
      void'(cur_q.pop_front());
      if (m_pend_v) begin
        load_cur(m_pend_d, m_pend_c);
        if (rv) begin m_pend_d = d; m_pend_c = c; end
        else m_pend_v = 1'b0;
      end else if (rv) begin
        load_cur(d, c);
      end
    end else begin
      if (rdy) void'(cur_q.pop_front());
      if (rv) begin
        if (!m_pend_v) begin m_pend_v = 1'b1; m_pend_d = d; m_pend_c = c; end
        else m_ovr = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, rdy);
  endtask

  initial begin
    sync_rst = 1'b1; res_valid = 1'b0; res_data = '0; res_carry = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    // Reset state: every output low.
    @(negedge clk);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Basic frame.
    step(1'b0, 1'b1, 16'hA55A, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Backpressure: three stalled cycles on the first beat.
    step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // Pending and overrun.
    step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
    idle(8, 1'b1);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Back-to-back: new result coincides with the last-beat accept.
    step(1'b0, 1'b1, 16'hCAFE, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
`ifdef ALU_SER_CARRY_BYTE_EN
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
`endif
    step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
    idle(5, 1'b1);

    // Mid-frame reset after the first beat.
    step(1'b0, 1'b1, 16'h5678, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h9ABC, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Carry-dependent frames.
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    idle(4, 1'b1);
    step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3,
           DW'($urandom), 1'($urandom), $urandom_range(0, 9) < 6);
    end
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream stage of the ALU arithmetic unit. Captures each registered arithmetic result together with its carry, and emits it as a sequence of OUT_WIDTH-bit beats on a valid/ready stream toward the TX FIFO / UART TX path.
- Holds one result in flight plus one pending result, so back-to-back ALU operations are not lost while the output is stalled.

Parameters:
- DATA_WIDTH, 16, width of the ALU result word; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, width of one output beat.
- NUM_BEATS, DATA_WIDTH/OUT_WIDTH (localparam, 2 at default), data beats per result.

Ports:
- clk  in  1  single clock for the block.
- sync_rst  in  1  synchronous, active-high reset.
- res_data  in  DATA_WIDTH  registered ALU result.
- res_carry  in  1  carry associated with res_data.
- res_valid  in  1  one-cycle strobe; res_data/res_carry are valid this cycle.
- out_data  out  OUT_WIDTH  current output beat.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- busy  out  1  high in SEND or while the pending slot is full.
- overrun  out  1  sticky flag: a result was dropped; cleared only by sync_rst.

Behaviour:
- Reset: on a clk edge with sync_rst=1, all outputs and internal state go to 0 and the FSM goes to IDLE. Reset in mid-frame abandons the frame and the pending slot.
- State IDLE:
  - out_valid=0.
  - On res_valid: load shift register with {res_data, status} and set beat_cnt to the total beat count; next state SEND.
  - Latency: res_valid in cycle N gives out_valid=1 in cycle N+1.
- State SEND:
  - out_valid=1; out_data = most-significant unsent byte. Order is MS byte first, LS last.
  - On accept (out_valid && out_ready): shift left by OUT_WIDTH and decrement beat_cnt.
  - out_data and out_valid are held stable while out_ready=0.
- Last-beat accept (beat_cnt==1 and accepted):
  - If pending is full, load pending into the shift register and stay in SEND with no bubble. A res_valid in the same cycle goes into the pending slot, with no overrun.
  - Else, if res_valid in the same cycle, load it directly and stay in SEND.
  - Else go to IDLE.
- res_valid in SEND when not on the last-beat accept:
  - Pending empty: capture into pending.
  - Pending full: drop the new result and set overrun=1. Pending keeps the older result.
- busy = (state==SEND) || pending_full.
- Frame integrity: each result is emitted as exactly one contiguous frame. No reordering; pending is emitted after the current frame.

Optional Feature:
- Macro: ALU_SER_CARRY_BYTE_EN.
- Defined: each frame carries NUM_BEATS+1 beats. The final beat is a status byte {OUT_WIDTH-1 zeros, carry}; total beats = 3 at default.
- Not defined: frame is NUM_BEATS beats. Carry is captured but never emitted, and res_carry has no effect on any output.

Test Plan:
1. Basic frame (macro off): res_data=16'hA55A, one-cycle res_valid, out_ready=1 -> beats 8'hA5 then 8'h5A on consecutive cycles starting the cycle after res_valid; out_valid and busy then fall to 0.
2. Backpressure: res_data=16'h1234; out_ready=0 for 3 cycles, then 1 -> out_data holds 8'h12 with out_valid=1 through the stall, then 8'h12 and 8'h34 are accepted; no duplicated beats.
3. Pending and overrun: out_ready=0; send results 16'h0001, 16'h0002, 16'h0003 on consecutive cycles; then out_ready=1 -> overrun=1 after the third; output stream is 00,01,00,02; 16'h0003 is never emitted; overrun stays 1 until sync_rst.
4. Back-to-back, no bubble: res_valid for 16'hBEEF coincides with the last-beat accept of 16'hCAFE -> stream CA,FE,BE,EF with out_valid continuously high; overrun=0.
5. Mid-frame reset: sync_rst=1 after the first beat of 16'h5678 is accepted -> next cycle out_valid=0, busy=0, overrun=0; a subsequent res_valid with 16'h9ABC emits 9A,BC only.
6. ALU_SER_CARRY_BYTE_EN defined: res_data=16'hFFFF with res_carry=1 -> beats FF,FF,01; then res_data=16'h0010 with res_carry=0 -> beats 00,10,00.
